// File: rtl/mc_core_pkg.sv
// rtl/mc_core_pkg.sv - shared types and helpers for the multi-cycle core
// Contents: opcode_e (instruction opcodes), state_e (sequencer states),
//   calc_rw/calc_iw (register-index and instruction width derivation),
//   jlut (branch target lookup, masked to the requested PC width).
package mc_core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_LDC = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_BZ  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  function automatic int calc_rw(input int nreg);
    return $clog2(nreg);
  endfunction

  function automatic int calc_iw(input int rw);
    return 3 + 2 * rw;
  endfunction

  // Branch target table: 0->0, 1->4, n->8n, wrapped to the PC width.
  function automatic logic [31:0] jlut(input int unsigned idx, input int unsigned pcw);
    logic [31:0] v_tgt;
    logic [31:0] v_mask;
    if (idx == 0)      v_tgt = 32'd0;
    else if (idx == 1) v_tgt = 32'd4;
    else               v_tgt = idx * 8;
    v_mask = (pcw >= 32) ? '1 : ((32'd1 << pcw) - 32'd1);
    return v_tgt & v_mask;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - NREG x DW register file, two async reads, one sync write
// Ports:
//   i_clk, i_rst_n         clock, async active-low clear of every entry
//   i_we/i_waddr/i_wdata   synchronous write port
//   i_raddr_a/o_rdata_a    combinational read port A
//   i_raddr_b/o_rdata_b    combinational read port B
module mc_regfile
  import mc_core_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8,
  localparam int RW  = calc_rw(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_raddr_a,
  input  logic [RW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle core: FETCH/EXEC/MEM sequencer over req/ack memories
// Optional feature macro: MC_CORE_PERF_EN (cycle / retired-instruction counters).
// Ports:
//   Clk, Reset_n                       clock, async active-low reset
//   Start                              run from PC 0 (honoured in IDLE/HALT only)
//   imem_req/imem_addr/imem_ack/imem_data          instruction fetch handshake
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata  data handshake
//   Done                               high while halted
//   perf_cycles, perf_retired          counters, zero unless MC_CORE_PERF_EN
module mc_core
  import mc_core_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int PCW  = 8,
  localparam int RW  = calc_rw(NREG),
  localparam int IW  = calc_iw(RW)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           Done,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_retired
);

  state_e         r_state, w_next;
  logic [PCW-1:0] r_pc, w_pc_inc, w_pc_next;
  logic [IW-1:0]  r_ir;

  opcode_e        w_op;
  logic [RW-1:0]  w_ra, w_rb;
  logic [DW-1:0]  w_imm, w_rd_a, w_rd_b, w_alu;
  logic           w_is_halt, w_br_taken, w_start;

  logic           w_rf_we;
  logic [RW-1:0]  w_rf_waddr;
  logic [DW-1:0]  w_rf_wdata;

  assign w_op      = opcode_e'(r_ir[IW-1:IW-3]);
  assign w_ra      = r_ir[2*RW-1:RW];
  assign w_rb      = r_ir[RW-1:0];
  assign w_imm     = DW'(r_ir[2*RW-1:0]);
  assign w_is_halt = (w_op == OP_BZ) && (&w_ra) && (&w_rb);

  mc_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_ra),
    .i_raddr_b (w_rb),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_rd_a + w_rd_b;
      OP_SUB:  w_alu = w_rd_a - w_rd_b;
      OP_AND:  w_alu = w_rd_a & w_rd_b;
      OP_XOR:  w_alu = w_rd_a ^ w_rd_b;
      default: w_alu = '0;
    endcase
  end

  // BZ samples R[ra] from the read port, i.e. before any writeback this cycle.
  assign w_br_taken = (w_op == OP_BZ) && (w_rd_a == '0);
  assign w_pc_inc   = r_pc + PCW'(1);
  assign w_pc_next  = w_br_taken ? PCW'(jlut(32'(w_rb), PCW)) : w_pc_inc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_waddr = w_ra;
    w_rf_wdata = w_alu;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          w_next  = S_FETCH;
          w_start = 1'b1;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          OP_LDC: begin
            w_rf_we    = 1'b1;
            w_rf_waddr = '0;
            w_rf_wdata = w_imm;
            w_next     = S_FETCH;
          end
          OP_LD, OP_ST: w_next = S_MEM;
          OP_BZ:        w_next = w_is_halt ? S_HALT : S_FETCH;
          default: begin
            w_rf_we = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_op == OP_ST);
        if (dmem_ack) begin
          w_rf_we    = (w_op == OP_LD);
          w_rf_wdata = dmem_rdata;
          w_next     = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // PC advances on leaving EXEC; LD/ST advance early since imem is idle in MEM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (w_start)
        r_pc <= '0;
      else if ((r_state == S_EXEC) && (w_next != S_HALT))
        r_pc <= w_pc_next;
      if ((r_state == S_FETCH) && imem_ack)
        r_ir <= imem_data;
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = w_rd_b;
  assign dmem_wdata = w_rd_a;
  assign Done       = (r_state == S_HALT);

`ifdef MC_CORE_PERF_EN
  logic        w_retire;
  logic [31:0] r_cycles, r_retired;

  assign w_retire = ((r_state == S_EXEC) && (w_next != S_MEM)) ||
                    ((r_state == S_MEM) && dmem_ack);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cycles  <= '0;
      r_retired <= '0;
    end else if (w_start) begin
      r_cycles  <= '0;
      r_retired <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_HALT)) r_cycles <= r_cycles + 32'd1;
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

  assign perf_cycles  = r_cycles;
  assign perf_retired = r_retired;
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - self-checking bench for mc_core
module tb_mc_core;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        Done;
  logic [31:0] perf_cycles, perf_retired;

  logic        Start2 = 1'b0;
  logic        imem2_req, imem2_ack;
  logic [7:0]  imem2_addr;
  logic [10:0] imem2_data;
  logic        dmem2_req, dmem2_we, dmem2_ack;
  logic [15:0] dmem2_addr, dmem2_wdata, dmem2_rdata;
  logic        Done2;
  logic [31:0] perf2_cycles, perf2_retired;

  always #5 Clk = ~Clk;

  mc_core u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .Done(Done),
    .perf_cycles(perf_cycles), .perf_retired(perf_retired)
  );

  mc_core #(.DW(16), .NREG(16), .PCW(8)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start2),
    .imem_req(imem2_req), .imem_addr(imem2_addr), .imem_ack(imem2_ack), .imem_data(imem2_data),
    .dmem_req(dmem2_req), .dmem_we(dmem2_we), .dmem_addr(dmem2_addr), .dmem_wdata(dmem2_wdata),
    .dmem_ack(dmem2_ack), .dmem_rdata(dmem2_rdata), .Done(Done2),
    .perf_cycles(perf2_cycles), .perf_retired(perf2_retired)
  );

  // Memory models: ack after a programmable number of wait cycles.
  logic [8:0]  prog  [256];
  logic [10:0] prog2 [256];
  int i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;

  assign imem_data   = prog[imem_addr];
  assign imem_ack    = imem_req && (i_cnt >= i_wait);
  assign dmem_ack    = dmem_req && (d_cnt >= d_wait);
  assign dmem_rdata  = 8'hA5;
  assign imem2_data  = prog2[imem2_addr];
  assign imem2_ack   = imem2_req;
  assign dmem2_ack   = dmem2_req;
  assign dmem2_rdata = 16'h0000;

  always @(posedge Clk) begin
    i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
    d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard of expected data-memory transactions.
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ncyc;
  } txn_t;
  txn_t sb[$];
  txn_t m_e;
  int   m_cyc = 0;
  logic [7:0] m_a0;
  logic m_moved;

  task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input int ncyc);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.ncyc = ncyc;
    sb.push_back(t);
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      m_cyc = 0;
    end else if (dmem_req) begin
      m_cyc = m_cyc + 1;
      if (m_cyc == 1) begin
        m_a0    = dmem_addr;
        m_moved = 1'b0;
      end else if (dmem_addr !== m_a0) begin
        m_moved = 1'b1;
      end
      if (dmem_ack) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got we %0b addr %0h, expected no transaction", dmem_we, dmem_addr);
        end else begin
          m_e = sb.pop_front();
          chk("dmem_we", dmem_we, m_e.we);
          chk("dmem_addr", dmem_addr, m_e.addr);
          if (m_e.we) chk("dmem_wdata", dmem_wdata, m_e.wdata);
          chk("dmem_req_cycles", m_cyc, m_e.ncyc);
          chk("dmem_addr_stable", m_moved, 0);
        end
        m_cyc = 0;
      end
    end
  end

  logic [15:0] st2_addr = '0, st2_data = '0;
  int st2_seen = 0;
  always @(negedge Clk) begin
    if (Reset_n && dmem2_req && dmem2_ack && dmem2_we) begin
      st2_addr = dmem2_addr;
      st2_data = dmem2_wdata;
      st2_seen++;
    end
  end

  localparam logic [8:0] HALT_I = 9'h1FF;

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
    return {op, ra, rb};
  endfunction

  function automatic logic [8:0] ldc(input logic [5:0] imm);
    return {3'd4, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = HALT_I;
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  // Pulses Start, then counts edges until Done (bounded).
  task automatic run_prog(input string nm, input int exp_cyc);
    int cyc;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    cyc = 0;
    while (Done !== 1'b1 && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
    end
    chk({nm, "_done"}, Done, 1);
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [5:0] a;
    logic [5:0] b;
    logic [7:0] res;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int cyc2;
    vecs[0] = '{3'd0, 6'd3,    6'd4,    8'h07};
    vecs[1] = '{3'd0, 6'd63,   6'd63,   8'h7E};
    vecs[2] = '{3'd1, 6'd0,    6'd1,    8'hFF};
    vecs[3] = '{3'd1, 6'd10,   6'd3,    8'h07};
    vecs[4] = '{3'd2, 6'h2A,   6'h0F,   8'h0A};
    vecs[5] = '{3'd2, 6'h3F,   6'h00,   8'h00};
    vecs[6] = '{3'd3, 6'h2A,   6'h15,   8'h3F};
    vecs[7] = '{3'd3, 6'h33,   6'h33,   8'h00};

    clear_prog();
    for (int i = 0; i < 256; i++) prog2[i] = 11'h7FF;

    // Reset state
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_ctrl", {imem_req, dmem_req, dmem_we, Done}, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_bus", {dmem_addr, dmem_wdata}, 0);
    chk("rst_perf", perf_cycles | perf_retired, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Reset in the middle of a stalled fetch at PC 1
    prog[0] = ldc(6'd3); prog[1] = ldc(6'd4); prog[2] = HALT_I;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk); i_wait = 5;
    @(negedge Clk);
    chk("midfetch_req", imem_req, 1);
    chk("midfetch_addr", imem_addr, 1);
    Reset_n = 1'b0;
    #1;
    chk("midfetch_rst_req", imem_req, 0);
    chk("midfetch_rst_addr", imem_addr, 0);
    @(negedge Clk); Reset_n = 1'b1; i_wait = 0;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    repeat (8) @(negedge Clk);
    chk("restart_done", Done, 1);

    // LDC 5; ADD R0,R0; HALT, then expose R0 through a store
    clear_prog();
    prog[0] = ldc(6'd5); prog[1] = enc(3'd0, 3'd0, 3'd0);
    run_prog("ldc_add", 6);
`ifdef MC_CORE_PERF_EN
    chk("ldc_add_perf_cycles", perf_cycles, 6);
    chk("ldc_add_perf_retired", perf_retired, 3);
`else
    chk("ldc_add_perf_cycles", perf_cycles, 0);
    chk("ldc_add_perf_retired", perf_retired, 0);
`endif
    clear_prog();
    prog[0] = enc(3'd6, 3'd0, 3'd0);
    push(1'b1, 8'd10, 8'd10, 1);
    run_prog("keep_r0", 5);
`ifdef MC_CORE_PERF_EN
    chk("keep_r0_perf_retired", perf_retired, 2);
`else
    chk("keep_r0_perf_retired", perf_retired, 0);
`endif

    // ALU vector table: R1 = a op b, stored at address b
    for (int k = 0; k < 8; k++) begin
      clear_prog();
      prog[0] = enc(3'd3, 3'd1, 3'd1);
      prog[1] = ldc(vecs[k].a);
      prog[2] = enc(3'd3, 3'd1, 3'd0);
      prog[3] = ldc(vecs[k].b);
      prog[4] = enc(vecs[k].op, 3'd1, 3'd0);
      prog[5] = enc(3'd6, 3'd1, 3'd0);
      push(1'b1, {2'b00, vecs[k].b}, vecs[k].res, 1);
      run_prog($sformatf("vec%0d", k), 15);
    end

    // LD/ST with three wait states, including LD R0,[R0]
    clear_prog();
    d_wait = 3;
    prog[0] = ldc(6'h20);
    prog[1] = enc(3'd5, 3'd1, 3'd0);
    prog[2] = enc(3'd6, 3'd1, 3'd0);
    prog[3] = enc(3'd5, 3'd0, 3'd0);
    prog[4] = enc(3'd6, 3'd0, 3'd0);
    push(1'b0, 8'h20, 8'h00, 4);
    push(1'b1, 8'h20, 8'hA5, 4);
    push(1'b0, 8'h20, 8'h00, 4);
    push(1'b1, 8'hA5, 8'hA5, 4);
    run_prog("ld_wait", 28);
    d_wait = 0;

    // ST R1 -> mem[R2] with R1=0x7F, R2=0x10
    clear_prog();
    prog[0] = enc(3'd3, 3'd1, 3'd1);
    prog[1] = ldc(6'd63);
    prog[2] = enc(3'd3, 3'd1, 3'd0);
    prog[3] = enc(3'd0, 3'd1, 3'd1);
    prog[4] = ldc(6'd1);
    prog[5] = enc(3'd0, 3'd1, 3'd0);
    prog[6] = enc(3'd3, 3'd2, 3'd2);
    prog[7] = ldc(6'd16);
    prog[8] = enc(3'd3, 3'd2, 3'd0);
    prog[9] = enc(3'd6, 3'd1, 3'd2);
    push(1'b1, 8'h10, 8'h7F, 1);
    run_prog("st_r1_r2", 23);

    // BZ taken via jlut(1)=4
    clear_prog();
    prog[0] = ldc(6'd0); prog[1] = enc(3'd7, 3'd0, 3'd1);
    prog[2] = ldc(6'd2); prog[3] = enc(3'd6, 3'd0, 3'd0);
    prog[4] = ldc(6'd5); prog[5] = enc(3'd6, 3'd0, 3'd0);
    push(1'b1, 8'd5, 8'd5, 1);
    run_prog("bz_taken1", 11);

    // BZ taken via jlut(2)=16
    clear_prog();
    prog[0]  = ldc(6'd0); prog[1] = enc(3'd7, 3'd0, 3'd2);
    prog[16] = ldc(6'd16); prog[17] = enc(3'd6, 3'd0, 3'd0);
    push(1'b1, 8'd16, 8'd16, 1);
    run_prog("bz_taken2", 11);

    // BZ not taken on a register holding 3
    clear_prog();
    prog[0] = ldc(6'd3); prog[1] = enc(3'd7, 3'd0, 3'd1);
    prog[2] = enc(3'd6, 3'd0, 3'd0);
    push(1'b1, 8'd3, 8'd3, 1);
    run_prog("bz_not_taken", 9);

    // PC wraps from 255 to 0: second visit of PC 0 sees R5=1
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = enc(3'd0, 3'd7, 3'd7);
    prog[0]   = enc(3'd7, 3'd5, 3'd1);
    prog[1]   = enc(3'd6, 3'd5, 3'd5);
    prog[2]   = HALT_I;
    prog[254] = ldc(6'd1);
    prog[255] = enc(3'd3, 3'd5, 3'd0);
    push(1'b1, 8'd1, 8'd1, 1);
    run_prog("pc_wrap", 513);

    // DW=16, NREG=16: SUB 0-1 -> 0xFFFF
    prog2[0] = {3'd4, 8'd1};
    prog2[1] = {3'd1, 4'd1, 4'd0};
    prog2[2] = {3'd6, 4'd1, 4'd0};
    @(negedge Clk); Start2 = 1'b1;
    @(negedge Clk); Start2 = 1'b0;
    cyc2 = 0;
    while (Done2 !== 1'b1 && cyc2 < 3000) begin
      @(negedge Clk);
      cyc2++;
    end
    chk("w16_done", Done2, 1);
    chk("w16_cycles", cyc2, 9);
    chk("w16_st_count", st2_seen, 1);
    chk("w16_st_addr", st2_addr, 16'h0001);
    chk("w16_st_data", st2_data, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multi-cycle successor to the single-cycle processor top: fetch, execute, memory and halt are sequenced by an FSM instead of completing in one cycle. Instruction and data memories sit outside the block behind req/ack handshakes, so wait-state memories are supported. Width, register count and PC width are generic. A program runs from PC 0 after `Start` and raises `Done` on HALT.

## Interface
- `DW`, 8: datapath/register width.
- `NREG`, 8: register count, power of two ≥4; `RW = $clog2(NREG)`.
- `PCW`, 8: PC and instruction-address width.
- `IW`, derived `3 + 2*RW`: instruction width; never overridden.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: begin execution from PC 0 (sampled in IDLE/HALT).
- `imem_req` out 1, `imem_addr` out PCW: instruction fetch request and address (= PC).
- `imem_ack` in 1, `imem_data` in IW: fetch complete; data valid in ack cycle.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out DW, `dmem_wdata` out DW: data request.
- `dmem_ack` in 1, `dmem_rdata` in DW: data complete; rdata valid in ack cycle.
- `Done` out 1: high in HALT.
- `perf_cycles` out 32, `perf_retired` out 32: performance counters (see Configuration).

## Operation
- Encoding: `[IW-1:IW-3]` op, `ra` = next RW bits, `rb` = low RW bits; `imm` = `{ra,rb}` zero-extended to DW.
- op 0 ADD, 1 SUB, 2 AND, 3 XOR: `R[ra] <= R[ra] op R[rb]`, modulo 2^DW, no flags.
- op 4 LDC: `R[0] <= imm`.
- op 5 LD: `R[ra] <= mem[R[rb]]`. op 6 ST: `mem[R[rb]] <= R[ra]`.
- op 7, ra = rb = all-ones: HALT. Otherwise BZ: if `R[ra]==0`, PC <= `jlut(rb)`, else PC+1.
- Non-branch instructions: PC <= PC+1, wrapping from 2^PCW−1 to 0.
- FSM states: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE: `Start` goes to FETCH with PC=0.
  - FETCH: `imem_req`=1; on `imem_ack`, latch IR and go to EXEC.
  - EXEC: ALU/LDC/BZ write back and go to FETCH; LD/ST go to MEM; HALT goes to HALT.
  - MEM: `dmem_req`=1 with `dmem_addr=R[rb]`; `dmem_we`=1 for ST, with `wdata=R[ra]`. On `dmem_ack`: LD writes `R[ra]`; go to FETCH.
  - HALT: `Done`=1; `Start` goes to FETCH with PC=0; registers keep their values.
- Request outputs depend only on state (registered state, combinational decode). Address and wdata are held stable while req is high.

## Timing
- Reset (async, any state, mid-handshake included): state IDLE, PC 0, IR 0, all registers 0, counters 0. All outputs 0 immediately, not on the next edge.
- Latency with zero wait-state memories (ack in the first req cycle):
  - ALU/LDC/BZ/HALT: 2 cycles.
  - LD/ST: 3 cycles.
  - Each cycle ack stays low adds 1 cycle.
- BZ tests the register value before any writeback in the same cycle. No forwarding is needed, since writes retire before the next fetch.
- An ack arriving when no req is outstanding is ignored. `Start` is ignored outside IDLE/HALT.
- LD with `ra==rb`: the loaded value overwrites the address register.

## Configuration
- `MC_CORE_PERF_EN` defined:
  - `perf_cycles` increments every cycle outside IDLE/HALT.
  - `perf_retired` increments on each transition out of EXEC (non-memory instructions) or MEM (on ack).
  - HALT itself counts as retired.
  - Both counters wrap at 2^32 and clear on reset and on `Start`.
- Not defined: both ports tied to 0 and no counter flops are synthesised. The port list is unchanged.

## Structure
- `mc_core_pkg`:
  - opcode enum and state enum;
  - `jlut(index)` function returning PCW-bit targets (index 0→0, 1→4, others→index*8 mod 2^PCW);
  - RW/IW derivation helpers.
- One sub-module, `mc_regfile`: NREG×DW, two async read ports, one sync write port, async active-low clear.

## Test plan
- Reset mid-FETCH with `imem_req`=1 → req drops immediately; after release, `Start` fetches address 0.
- Program LDC 5; ADD R0,R0; HALT with zero-wait memory → R0=10, `Done` high 6 cycles after `Start`, `perf_retired`=3.
- LD with `dmem_ack` delayed 3 cycles, `R[rb]`=0x20, rdata=0xA5 → addr 0x20 held for 4 req cycles; `R[ra]`=0xA5.
- ST R1→mem[R2], R1=0x7F, R2=0x10 → one req, we=1, addr 0x10, wdata 0x7F.
- BZ on register 0 with rb=1 → PC=4; same with register=3 → PC+1. PC at 255 with non-branch → wraps to 0.
- SUB 0−1 with DW=8 → 0xFF. Repeat with DW=16, NREG=16 → 0xFFFF, IW=11.
